// File: rtl/half_adder.sv
// Registered WIDTH-lane half adder with a saturating carry-event counter.
// Define HALF_ADDER_PARITY_EN to add the registered sum_parity output.

module half_adder_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum   <= 1'b0;
         carry <= 1'b0;
      end else if (en) begin
         sum   <= a ^ b;
         carry <= a & b;
      end
   end

endmodule

module half_adder #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clr_count,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic             carry_any,
   output logic [CNT_W-1:0] carry_count
`ifdef HALF_ADDER_PARITY_EN
   ,
   output logic             sum_parity
`endif
);

   localparam int STAGES = 1;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } req_t;

   req_t              req;
   logic [STAGES:0]   vld_pipe;
   logic              carry_hit;
   logic [CNT_W-1:0]  cnt_max;

   assign req         = '{a: a, b: b};
   assign vld_pipe[0] = in_valid;
   assign cnt_max     = '1;
   // Gated by in_valid so X on idle operands never reaches the counter.
   assign carry_hit   = in_valid & (|(req.a & req.b));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe[STAGES:1] <= '0;
      else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

   assign out_valid = vld_pipe[STAGES];

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_lane u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (in_valid),
         .a     (req.a[i]),
         .b     (req.b[i]),
         .sum   (sum[i]),
         .carry (carry[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        carry_any <= 1'b0;
      else if (in_valid) carry_any <= |(req.a & req.b);
   end

   // Clear has priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                carry_count <= '0;
      else if (clr_count)                        carry_count <= '0;
      else if (carry_hit && carry_count != cnt_max) carry_count <= carry_count + 1'b1;
   end

`ifdef HALF_ADDER_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        sum_parity <= 1'b0;
      else if (in_valid) sum_parity <= ^(req.a ^ req.b);
   end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder (WIDTH=4, CNT_W=2); WIDTH=1 cases drive lane 0 only.
// Parity checks are compiled in when HALF_ADDER_PARITY_EN is defined.

module tb_half_adder;

   localparam int W = 4;
   localparam int C = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a, b;
   logic         clr_count;
   logic         out_valid;
   logic [W-1:0] sum, carry;
   logic         carry_any;
   logic [C-1:0] carry_count;
`ifdef HALF_ADDER_PARITY_EN
   logic         sum_parity;
`endif

   typedef struct {
      logic [W-1:0] s;
      logic [W-1:0] c;
      logic         any;
   } exp_t;

   exp_t   sbq[$];
   exp_t   last;
   exp_t   e;
   int     model_cnt;
   int     n_chk  = 0;
   int     n_fail = 0;

   always #5 clk = ~clk;

   half_adder #(.WIDTH(W), .CNT_W(C)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .a           (a),
      .b           (b),
      .clr_count   (clr_count),
      .out_valid   (out_valid),
      .sum         (sum),
      .carry       (carry),
      .carry_any   (carry_any),
      .carry_count (carry_count)
`ifdef HALF_ADDER_PARITY_EN
      ,
      .sum_parity  (sum_parity)
`endif
   );

   // Drive one cycle of stimulus, update the model, land 1 ns after the capturing edge.
   task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic clr);
      exp_t x;
      in_valid = v; a = av; b = bv; clr_count = clr;
      if (v) begin
         x.s = av ^ bv; x.c = av & bv; x.any = |(av & bv);
         sbq.push_back(x);
         last = x;
      end
      if (clr) model_cnt = 0;
      else if (v && |(av & bv) && model_cnt != (1 << C) - 1) model_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; clr_count = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_chk++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got %b want 0", sum); end
      n_chk++; if (carry !== '0) begin n_fail++; $display("FAIL reset_carry got %b want 0", carry); end
      n_chk++; if (carry_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", carry_count); end
      @(negedge clk); rst_n = 1'b1;
      sbq.delete(); model_cnt = 0;
      last.s = '0; last.c = '0; last.any = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_width1;
      logic [1:0] pat [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, {3'b000, pat[i][1]}, {3'b000, pat[i][0]}, 1'b0);
         n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL w1_out_valid[%0d] got %b want 1", i, out_valid); end
         if (sbq.size() == 0) begin n_chk++; n_fail++; $display("FAIL w1_queue_empty[%0d] got 0 want 1", i); end
         else begin
            e = sbq.pop_front();
            n_chk++;
            if (sum[0] !== e.s[0] || carry[0] !== e.c[0]) begin
               n_fail++; $display("FAIL w1_sum_carry[%0d] got s=%b c=%b want s=%b c=%b", i, sum[0], carry[0], e.s[0], e.c[0]);
            end
         end
      end
      n_chk++; if (carry_count !== C'(model_cnt)) begin n_fail++; $display("FAIL w1_count got %0d want %0d", carry_count, model_cnt); end
   endtask

   task automatic test_lanes;
      step(1'b1, 4'b1011, 4'b0110, 1'b0);
      e = sbq.pop_front();
      n_chk++;
      if (out_valid !== 1'b1 || sum !== e.s || carry !== e.c || carry_any !== e.any) begin
         n_fail++; $display("FAIL lanes got v=%b s=%b c=%b any=%b want v=1 s=%b c=%b any=%b",
                            out_valid, sum, carry, carry_any, e.s, e.c, e.any);
      end
      // Idle cycle with unknown operands: everything holds, out_valid drops.
      step(1'b0, 'x, 'x, 1'b0);
      n_chk++;
      if (out_valid !== 1'b0 || sum !== last.s || carry !== last.c || carry_any !== last.any) begin
         n_fail++; $display("FAIL lanes_hold got v=%b s=%b c=%b any=%b want v=0 s=%b c=%b any=%b",
                            out_valid, sum, carry, carry_any, last.s, last.c, last.any);
      end
      n_chk++; if (carry_count !== C'(model_cnt)) begin n_fail++; $display("FAIL idle_x_count got %0d want %0d", carry_count, model_cnt); end
   endtask

   task automatic test_saturation;
      int want [5] = '{1, 2, 3, 3, 3};
      step(1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'b0100, 4'b0101, 1'b0);
         void'(sbq.pop_front());
         n_chk++;
         if (carry_count !== C'(want[i]) || model_cnt != want[i]) begin
            n_fail++; $display("FAIL sat_count[%0d] got %0d want %0d", i, carry_count, want[i]);
         end
      end
      step(1'b1, 4'b1111, 4'b1000, 1'b1);
      void'(sbq.pop_front());
      n_chk++; if (carry_count !== '0) begin n_fail++; $display("FAIL clr_priority got %0d want 0", carry_count); end
   endtask

   task automatic test_back_to_back;
      logic         v;
      logic [W-1:0] ra, rb;
      for (int i = 0; i < 24; i++) begin
         v  = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
         ra = W'($urandom); rb = W'($urandom);
         step(v, ra, rb, (i == 17));
         if (v) begin
            e = sbq.pop_front();
            n_chk++;
            if (out_valid !== 1'b1 || sum !== e.s || carry !== e.c || carry_any !== e.any) begin
               n_fail++; $display("FAIL b2b[%0d] got v=%b s=%b c=%b any=%b want v=1 s=%b c=%b any=%b",
                                  i, out_valid, sum, carry, carry_any, e.s, e.c, e.any);
            end
         end else begin
            n_chk++;
            if (out_valid !== 1'b0 || sum !== last.s || carry !== last.c) begin
               n_fail++; $display("FAIL b2b_idle[%0d] got v=%b s=%b c=%b want v=0 s=%b c=%b",
                                  i, out_valid, sum, carry, last.s, last.c);
            end
         end
         n_chk++; if (carry_count !== C'(model_cnt)) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want %0d", i, carry_count, model_cnt); end
      end
   endtask

`ifdef HALF_ADDER_PARITY_EN
   task automatic test_parity;
      step(1'b1, 4'b0001, 4'b0010, 1'b0);
      void'(sbq.pop_front());
      n_chk++; if (sum !== 4'b0011 || sum_parity !== 1'b0) begin n_fail++; $display("FAIL parity0 got s=%b p=%b want s=0011 p=0", sum, sum_parity); end
      step(1'b1, 4'b0111, 4'b0000, 1'b0);
      void'(sbq.pop_front());
      n_chk++; if (sum_parity !== 1'b1) begin n_fail++; $display("FAIL parity1 got %b want 1", sum_parity); end
   endtask
`endif

   task automatic test_async_reset;
      step(1'b1, 4'b1111, 4'b0011, 1'b0);
      void'(sbq.pop_front());
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b want 1", out_valid); end
      in_valid = 1'b1; a = 4'b1111; b = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || sum !== '0 || carry !== '0 || carry_any !== 1'b0 || carry_count !== '0) begin
         n_fail++; $display("FAIL async_reset got v=%b s=%b c=%b any=%b cnt=%0d want all 0",
                            out_valid, sum, carry, carry_any, carry_count);
      end
      @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
      sbq.delete(); model_cnt = 0;
      last.s = '0; last.c = '0; last.any = 1'b0;
      step(1'b0, '0, '0, 1'b0);
      n_chk++; if (out_valid !== 1'b0 || sum !== '0) begin n_fail++; $display("FAIL post_reset got v=%b s=%b want v=0 s=0", out_valid, sum); end
   endtask

   initial begin
      test_reset();
      test_width1();
      test_lanes();
      test_saturation();
      test_back_to_back();
`ifdef HALF_ADDER_PARITY_EN
      test_parity();
`endif
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
